// File: rtl/acc_stream_driver.sv
// rtl/acc_stream_driver.sv - frame sequencer driving the signed accumulator core and emitting frame sums
// Optional ACC_DRV_CLEAR_CHECK_EN: sticky err_o when the accumulator is nonzero right after a clear.
module acc_stream_driver #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int COUNT_W    = 16,
  parameter int ACC_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic signed [DIN_WIDTH-1:0]  s_data_i,
  input  logic                         s_last_i,
  output logic                         acc_en_o,
  output logic                         acc_clear_o,
  output logic signed [DIN_WIDTH-1:0]  acc_data_o,
  input  logic signed [DOUT_WIDTH-1:0] acc_result_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic signed [DOUT_WIDTH-1:0] m_sum_o,
  output logic [COUNT_W-1:0]           m_count_o,
  output logic                         err_o
);

  localparam int DRAIN_W = 3;

  typedef enum logic [1:0] {
    ST_CLR,
    ST_ACCUM,
    ST_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [COUNT_W-1:0]   beat_q, beat_d;
  logic                 beat;
  logic                 capture;
  logic                 m_accept;

  assign s_ready_o = (state_q == ST_ACCUM);
  assign beat      = s_valid_i && s_ready_o;
  assign m_accept  = m_valid_o && m_ready_i;
  // Capture only once the result has settled and the single output slot is free or freeing.
  assign capture   = (state_q == ST_DRAIN) && (drain_q == '0) && (!m_valid_o || m_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLR;
      drain_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    beat_d  = beat_q;
    case (state_q)
      ST_CLR: begin
        beat_d  = '0;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (beat) begin
          beat_d = beat_q + COUNT_W'(1);
          if (s_last_i) begin
            drain_d = DRAIN_W'(ACC_LAT);
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - DRAIN_W'(1);
        end else if (capture) begin
          state_d = ST_CLR;
        end
      end
      default: state_d = ST_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_en_o    <= 1'b0;
      acc_clear_o <= 1'b0;
      acc_data_o  <= '0;
    end else begin
      acc_en_o    <= beat;
      acc_clear_o <= (state_q == ST_CLR);
      if (beat) begin
        acc_data_o <= s_data_i;
      end
    end
  end

  // Capture wins over accept so a waiting frame is replaced without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o <= 1'b0;
      m_sum_o   <= '0;
      m_count_o <= '0;
    end else if (capture) begin
      m_valid_o <= 1'b1;
      m_sum_o   <= acc_result_i;
      m_count_o <= beat_q;
    end else if (m_accept) begin
      m_valid_o <= 1'b0;
    end
  end

`ifdef ACC_DRV_CLEAR_CHECK_EN
  logic clear_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_seen_q <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      clear_seen_q <= acc_clear_o;
      if (clear_seen_q && (acc_result_i != '0)) begin
        err_o <= 1'b1;
      end
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_acc_stream_driver.sv
// tb/tb_acc_stream_driver.sv - directed self-checking bench for acc_stream_driver with an ACC_LAT=1 accumulator model
module tb_acc_stream_driver;
  localparam int DW  = 32;
  localparam int OW  = 32;
  localparam int CW  = 16;
  localparam int LAT = 1;

`ifdef ACC_DRV_CLEAR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 s_valid_i = 1'b0;
  logic                 s_ready_o;
  logic signed [DW-1:0] s_data_i = '0;
  logic                 s_last_i = 1'b0;
  logic                 acc_en_o;
  logic                 acc_clear_o;
  logic signed [DW-1:0] acc_data_o;
  logic signed [OW-1:0] acc_result_i;
  logic                 m_valid_o;
  logic                 m_ready_i = 1'b1;
  logic signed [OW-1:0] m_sum_o;
  logic [CW-1:0]        m_count_o;
  logic                 err_o;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  logic signed [OW-1:0] acc_q;
  logic                 clr_seen;
  logic                 inject = 1'b0;

  logic signed [DW-1:0] en_data[$];
  int                   en_cyc[$];
  logic signed [OW-1:0] res_sum[$];
  logic [CW-1:0]        res_cnt[$];
  int                   res_cyc[$];
  int                   clr_cnt = 0;
  int                   last_clr_cyc = 0;
  int                   prev_res_cyc = 0;

  acc_stream_driver #(
    .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .COUNT_W(CW), .ACC_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .acc_en_o(acc_en_o), .acc_clear_o(acc_clear_o), .acc_data_o(acc_data_o),
    .acc_result_i(acc_result_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_sum_o(m_sum_o), .m_count_o(m_count_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator core model: result reflects en/clear one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      clr_seen <= 1'b0;
    end else begin
      clr_seen <= acc_clear_o;
      if (acc_clear_o) acc_q <= '0;
      else if (acc_en_o) acc_q <= acc_q + acc_data_o;
    end
  end
  assign acc_result_i = (inject && clr_seen) ? 32'sd1 : acc_q;

  always @(negedge clk) begin
    if (acc_en_o) begin
      en_data.push_back(acc_data_o);
      en_cyc.push_back(cyc);
    end
    if (acc_clear_o) begin
      clr_cnt++;
      last_clr_cyc = cyc;
    end
    if (m_valid_o && m_ready_i) begin
      res_sum.push_back(m_sum_o);
      res_cnt.push_back(m_count_o);
      res_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    en_data.delete(); en_cyc.delete();
    res_sum.delete(); res_cnt.delete(); res_cyc.delete();
  endtask

  task automatic send_beat(input logic signed [DW-1:0] d, input logic last, output int hs);
    int guard;
    s_data_i = d; s_last_i = last; s_valid_i = 1'b1;
    guard = 0;
    while (!s_ready_o && guard < 100) begin
      step();
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_mis++;
      $display("FAIL beat_ready_timeout: s_ready_o=%0b required 1", s_ready_o);
    end
    step();
    hs = cyc;
    s_valid_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int guard;
    guard = 0;
    while (res_sum.size() < n && guard < 200) begin
      step();
      guard++;
    end
    n_cmp++;
    if (res_sum.size() < n) begin
      n_mis++;
      $display("FAIL result_timeout: got %0d results required %0d", res_sum.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({acc_en_o, acc_clear_o, s_ready_o, m_valid_o, err_o} !== 5'b0 || acc_data_o !== '0 ||
        m_sum_o !== '0 || m_count_o !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: en=%0b clr=%0b rdy=%0b mv=%0b err=%0b data=%0d sum=%0d cnt=%0d required all 0",
               acc_en_o, acc_clear_o, s_ready_o, m_valid_o, err_o, acc_data_o, m_sum_o, m_count_o);
    end
    rst_n = 1'b1;
    clr_cnt = 0;
    step();
    n_cmp++;
    if (acc_clear_o !== 1'b1 || s_ready_o !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_clear_pulse: clr=%0b rdy=%0b required 1 1", acc_clear_o, s_ready_o);
    end
    step();
    n_cmp++;
    if (acc_clear_o !== 1'b0 || clr_cnt != 1) begin
      n_mis++;
      $display("FAIL reset_clear_width: clr=%0b pulses=%0d required 0 1", acc_clear_o, clr_cnt);
    end
  endtask

  task automatic test_basic_frame();
    int hs;
    clear_logs();
    m_ready_i = 1'b1;
    send_beat(5, 1'b0, hs);
    send_beat(-3, 1'b0, hs);
    send_beat(10, 1'b0, hs);
    send_beat(7, 1'b1, hs);
    wait_results(1);
    n_cmp++;
    if (en_data.size() != 4 || en_data[0] !== 5 || en_data[1] !== -3 || en_data[2] !== 10 || en_data[3] !== 7) begin
      n_mis++;
      $display("FAIL basic_en_data: pulses=%0d required 4 carrying 5,-3,10,7", en_data.size());
    end
    n_cmp++;
    if (res_sum.size() > 0 && (res_sum[0] !== 19 || res_cnt[0] !== 16'd4)) begin
      n_mis++;
      $display("FAIL basic_result: sum=%0d cnt=%0d required 19 4", res_sum[0], res_cnt[0]);
    end
    n_cmp++;
    if (res_cyc.size() == 0 || res_cyc[0] != hs + 2) begin
      n_mis++;
      $display("FAIL basic_latency: valid_cycle=%0d required %0d", (res_cyc.size() > 0) ? res_cyc[0] : -1, hs + 2);
    end
    if (res_cyc.size() > 0) prev_res_cyc = res_cyc[0];
  endtask

  task automatic test_single_beat();
    int hs;
    clear_logs();
    send_beat(-8, 1'b1, hs);
    wait_results(1);
    n_cmp++;
    if (res_sum.size() > 0 && (res_sum[0] !== -8 || res_cnt[0] !== 16'd1)) begin
      n_mis++;
      $display("FAIL single_result: sum=%0d cnt=%0d required -8 1", res_sum[0], res_cnt[0]);
    end
    n_cmp++;
    if (en_cyc.size() != 1 || !(last_clr_cyc > prev_res_cyc && last_clr_cyc < en_cyc[0])) begin
      n_mis++;
      $display("FAIL single_clear_order: clear_cycle=%0d prev_result=%0d en_pulses=%0d required clear between",
               last_clr_cyc, prev_res_cyc, en_cyc.size());
    end
  endtask

  task automatic test_back_to_back_stall();
    int hs;
    bit stable;
    clear_logs();
    m_ready_i = 1'b0;
    send_beat(1, 1'b0, hs);
    send_beat(2, 1'b1, hs);
    send_beat(10, 1'b0, hs);
    send_beat(20, 1'b0, hs);
    send_beat(30, 1'b1, hs);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i > 4 && (m_valid_o !== 1'b1 || m_sum_o !== 3 || s_ready_o !== 1'b0)) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      n_mis++;
      $display("FAIL stall_hold: stable=%0b required 1", stable);
    end
    n_cmp++;
    if (m_valid_o !== 1'b1 || m_sum_o !== 3 || m_count_o !== 16'd2 || s_ready_o !== 1'b0) begin
      n_mis++;
      $display("FAIL stall_state: mv=%0b sum=%0d cnt=%0d rdy=%0b required 1 3 2 0",
               m_valid_o, m_sum_o, m_count_o, s_ready_o);
    end
    m_ready_i = 1'b1;
    wait_results(2);
    n_cmp++;
    if (res_sum.size() < 2 || res_sum[0] !== 3 || res_sum[1] !== 60 || res_cnt[1] !== 16'd3) begin
      n_mis++;
      $display("FAIL stall_release: results=%0d required 3 then 60 (cnt 3)", res_sum.size());
    end
    n_cmp++;
    if (res_cyc.size() < 2 || res_cyc[1] != res_cyc[0] + 1) begin
      n_mis++;
      $display("FAIL stall_no_bubble: accept cycles differ by %0d required 1",
               (res_cyc.size() >= 2) ? res_cyc[1] - res_cyc[0] : -1);
    end
  endtask

  task automatic test_gapped_valid();
    int hs;
    step(); step();
    clear_logs();
    send_beat(100, 1'b0, hs);
    step();
    send_beat(200, 1'b0, hs);
    step();
    send_beat(300, 1'b1, hs);
    wait_results(1);
    n_cmp++;
    if (en_cyc.size() != 3 || en_cyc[1] - en_cyc[0] != 2 || en_cyc[2] - en_cyc[1] != 2) begin
      n_mis++;
      $display("FAIL gapped_en_pulses: pulses=%0d required 3 spaced by 2 cycles", en_cyc.size());
    end
    n_cmp++;
    if (res_sum.size() > 0 && (res_sum[0] !== 600 || res_cnt[0] !== 16'd3)) begin
      n_mis++;
      $display("FAIL gapped_result: sum=%0d cnt=%0d required 600 3", res_sum[0], res_cnt[0]);
    end
  endtask

  task automatic test_reset_midframe();
    int hs;
    step(); step();
    clear_logs();
    send_beat(50, 1'b0, hs);
    send_beat(60, 1'b0, hs);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({acc_en_o, acc_clear_o, s_ready_o, m_valid_o} !== 4'b0 || acc_data_o !== '0 ||
        m_sum_o !== '0 || m_count_o !== '0) begin
      n_mis++;
      $display("FAIL midframe_reset: en=%0b clr=%0b rdy=%0b mv=%0b data=%0d sum=%0d cnt=%0d required all 0",
               acc_en_o, acc_clear_o, s_ready_o, m_valid_o, acc_data_o, m_sum_o, m_count_o);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (acc_clear_o !== 1'b1) begin
      n_mis++;
      $display("FAIL midframe_clear: clr=%0b required 1", acc_clear_o);
    end
    clear_logs();
    send_beat(4, 1'b0, hs);
    send_beat(4, 1'b1, hs);
    wait_results(1);
    n_cmp++;
    if (res_sum.size() > 0 && (res_sum[0] !== 8 || res_cnt[0] !== 16'd2)) begin
      n_mis++;
      $display("FAIL midframe_result: sum=%0d cnt=%0d required 8 2", res_sum[0], res_cnt[0]);
    end
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL err_clean: err=%0b required 0", err_o);
    end
  endtask

  task automatic test_clear_check();
    int hs;
    clear_logs();
    inject = 1'b1;
    send_beat(5, 1'b1, hs);
    wait_results(1);
    for (int i = 0; i < 4; i++) step();
    inject = 1'b0;
    n_cmp++;
    if (err_o !== EXP_ERR) begin
      n_mis++;
      $display("FAIL clear_check_err: err=%0b required %0b", err_o, EXP_ERR);
    end
    clear_logs();
    send_beat(9, 1'b1, hs);
    wait_results(1);
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (err_o !== EXP_ERR) begin
      n_mis++;
      $display("FAIL clear_check_sticky: err=%0b required %0b", err_o, EXP_ERR);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL clear_check_reset: err=%0b required 0", err_o);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_back_to_back_stall();
    test_gapped_valid();
    test_reset_midframe();
    test_clear_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
